// File: rtl/pc16_pkg.sv
// Shared definitions for the pc16 program counter and its return-address stack.
// Holds the machine word width, the default stack depth, the operation encoding
// and the priority decoder for the four control strobes.
package pc16_pkg;

  localparam int PC16_WORD_W        = 16;
  localparam int PC16_DEFAULT_DEPTH = 8;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_INC,
    OP_LOAD,
    OP_CALL,
    OP_RET
  } pc_op_t;

  // Fixed priority: RET > CALL > LOAD > INC; nothing asserted means hold.
  function automatic pc_op_t pc_decode_op(input logic ret,
                                          input logic call,
                                          input logic load,
                                          input logic inc);
    pc_op_t op;
    if (ret)       op = OP_RET;
    else if (call) op = OP_CALL;
    else if (load) op = OP_LOAD;
    else if (inc)  op = OP_INC;
    else           op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/pc16_ret_stack.sv
// LIFO of return addresses. The pointer equals the number of valid entries and
// never wraps: pushes while full and pops while empty are dropped here, and the
// parent decides whether that is an error. The top entry is read combinationally
// from the registered pointer. Storage is not reset; it is only observable
// through valid entries.
module pc16_ret_stack
  import pc16_pkg::*;
#(
  parameter int DEPTH  = PC16_DEFAULT_DEPTH,
  parameter int WORD_W = PC16_WORD_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] push_data,
  output logic [WORD_W-1:0] top_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_idx;
  logic [PTR_W-1:0]  top_idx;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // DEPTH is a power of two, so the low pointer bits address the storage
  // directly; at count == DEPTH the top index wraps to DEPTH-1 as intended.
  assign wr_idx  = count_q[PTR_W-1:0];
  assign top_idx = count_q[PTR_W-1:0] - PTR_ONE;

  assign top_data = mem_q[top_idx];
  assign count    = count_q;

  // Pointer next-state: at most one of push/pop is requested per cycle.
  always_comb begin
    count_d = count_q;
    if (push_ok)     count_d = count_q + CNT_ONE;
    else if (pop_ok) count_d = count_q - CNT_ONE;
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_idx] <= push_data;
  end

endmodule

// File: rtl/pc16_call_stack.sv
// 16-bit program counter with a hardware return-address stack.
// OUT is the instruction fetch address. Operations: hold, increment, jump,
// call (push OUT+1 then jump) and return (pop). Stack overflow/underflow set a
// sticky error that only reset clears.
// Optional build macro PC16_HALT_DETECT_EN: when defined, HALTED flags a jump
// to the current address (idle loop); when undefined HALTED is tied low.
module pc16_call_stack
  import pc16_pkg::*;
#(
  parameter int DEPTH  = PC16_DEFAULT_DEPTH,
  parameter int WORD_W = PC16_WORD_W,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WORD_W-1:0] IN,
  input  logic              LOAD,
  input  logic              INC,
  input  logic              CALL,
  input  logic              RET,
  output logic [WORD_W-1:0] OUT,
  output logic [CNT_W-1:0]  DEPTH_CNT,
  output logic              STK_FULL,
  output logic              STK_EMPTY,
  output logic              STK_ERR,
  output logic              HALTED
);

  localparam logic [WORD_W-1:0] PC_ONE = WORD_W'(1);

  pc_op_t            op;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic              err_q, err_d;
  logic              stk_push;
  logic              stk_pop;
  logic [WORD_W-1:0] ret_addr;
  logic [WORD_W-1:0] stk_top;
  logic [CNT_W-1:0]  stk_count;
  logic              stk_full;
  logic              stk_empty;

  assign op       = pc_decode_op(RET, CALL, LOAD, INC);
  assign ret_addr = pc_q + PC_ONE;

  pc16_ret_stack #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_ret_stack (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (ret_addr),
    .top_data  (stk_top),
    .count     (stk_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Next PC, stack requests and error flag for the winning operation.
  always_comb begin
    pc_d     = pc_q;
    err_d    = err_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (op)
      OP_INC:  pc_d = pc_q + PC_ONE;
      OP_LOAD: pc_d = IN;
      OP_CALL: begin
        // The jump is taken even when the return address cannot be saved.
        pc_d = IN;
        if (stk_full) err_d    = 1'b1;
        else          stk_push = 1'b1;
      end
      OP_RET: begin
        if (stk_empty) begin
          err_d = 1'b1;
        end else begin
          stk_pop = 1'b1;
          pc_d    = stk_top;
        end
      end
      default: pc_d = pc_q;
    endcase
  end

  // PC and sticky error registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

`ifdef PC16_HALT_DETECT_EN
  logic halted_q, halted_d;

  // Set on a jump to the current address; cleared once the PC moves again.
  always_comb begin
    halted_d = halted_q;
    if ((op == OP_LOAD) && (IN == pc_q)) halted_d = 1'b1;
    else if (pc_d != pc_q)               halted_d = 1'b0;
  end

  // Halt flag register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end

  assign HALTED = halted_q;
`else
  assign HALTED = 1'b0;
`endif

  assign OUT       = pc_q;
  assign DEPTH_CNT = stk_count;
  assign STK_FULL  = stk_full;
  assign STK_EMPTY = stk_empty;
  assign STK_ERR   = err_q;

endmodule
